// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and the register-file responder (slave).
interface apb_slave_regfile_if;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB register-file responder: DEPTH-1 read/write words plus a read-only
// completed-transfer counter in the top word, with programmable wait states.
module apb_slave_regfile #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    apb_slave_regfile_if.slave    apb
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned WW      = 4;
    localparam logic [AW-1:0] CNT_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_xfer_cnt;
    logic [WW-1:0] r_wait;
    logic [AW-1:0] r_idx;
    logic          r_write;
    logic          r_err;
    logic [31:0]   r_prdata;
    logic          r_pready;
    logic          r_pslverr;

    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_err;
    logic          w_setup;
    logic [31:0]   w_rd_word;

    // Setup-phase decode of the incoming address
    assign w_idx      = apb.Paddr[AW+1:2];
    assign w_in_range = (apb.Paddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_err      = !w_in_range || (apb.Paddr[1:0] != 2'b00) ||
                        (apb.Pwrite && (w_idx == CNT_IDX));
    assign w_setup    = apb.Psel && !apb.Penable;
    assign w_rd_word  = (w_idx == CNT_IDX) ? r_xfer_cnt : r_mem[w_idx];

    // Pready/Pslverr are precomputed one edge ahead so they come straight from flops
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_xfer_cnt <= '0;
            r_wait     <= '0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_state   <= S_ACCESS;
                        r_write   <= apb.Pwrite;
                        r_idx     <= w_idx;
                        r_err     <= w_err;
                        r_wait    <= WW'(WAIT_STATES);
                        r_pready  <= (WAIT_STATES == 0);
                        r_pslverr <= (WAIT_STATES == 0) && w_err;
                        r_prdata  <= (!apb.Pwrite && !w_err) ? w_rd_word : '0;
                    end
                end
                S_ACCESS: begin
                    if (!apb.Psel) begin
                        r_state   <= S_IDLE;
                        r_prdata  <= '0;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (r_pready) begin
                        if (r_write && !r_err) r_mem[r_idx] <= apb.Pwdata;
                        r_xfer_cnt <= r_xfer_cnt + 32'd1;
                        r_state    <= S_IDLE;
                        r_prdata   <= '0;
                        r_pready   <= 1'b0;
                        r_pslverr  <= 1'b0;
                    end else begin
                        r_wait    <= r_wait - WW'(1);
                        r_pready  <= (r_wait == WW'(1));
                        r_pslverr <= (r_wait == WW'(1)) && r_err;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign apb.Prdata  = r_prdata;
    assign apb.Pready  = r_pready;
    assign apb.Pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: two instances (0 and 3 wait states)
// compared against an array-based register/counter model.
module tb_apb_slave_regfile;
    localparam int DEPTH    = 16;
    localparam int CNT_WORD = DEPTH - 1;

    logic Hclk = 1'b0;
    logic Hreset;
    always #5 Hclk = ~Hclk;

    apb_slave_regfile_if bus0();
    apb_slave_regfile_if bus3();

    logic        d_psel  [2];
    logic        d_pen   [2];
    logic        d_pwr   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] q_rdata [2];
    logic        q_rdy   [2];
    logic        q_err   [2];

    assign bus0.Psel = d_psel[0];  assign bus0.Penable = d_pen[0];
    assign bus0.Pwrite = d_pwr[0]; assign bus0.Paddr = d_addr[0];
    assign bus0.Pwdata = d_wdata[0];
    assign bus3.Psel = d_psel[1];  assign bus3.Penable = d_pen[1];
    assign bus3.Pwrite = d_pwr[1]; assign bus3.Paddr = d_addr[1];
    assign bus3.Pwdata = d_wdata[1];
    assign q_rdata[0] = bus0.Prdata; assign q_rdy[0] = bus0.Pready; assign q_err[0] = bus0.Pslverr;
    assign q_rdata[1] = bus3.Prdata; assign q_rdy[1] = bus3.Pready; assign q_err[1] = bus3.Pslverr;

    apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .apb(bus0.slave));
    apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
        .Hclk(Hclk), .Hreset(Hreset), .apb(bus3.slave));

    int          ws_of [2] = '{0, 3};
    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] m_cnt [2];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++) begin
            m_cnt[b] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
        end
    endtask

    task automatic idle(input int b);
        d_psel[b] = 1'b0;
        d_pen[b]  = 1'b0;
    endtask

    // One full transfer; called and returns at a negedge, so calls chain back-to-back
    task automatic xfer(input int b, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          word;
        bit          done;
        word    = int'(addr[5:2]);
        exp_err = (addr > 32'h3F) || (addr[1:0] != 2'b00) || (wr && word == CNT_WORD);
        exp_rd  = (wr || exp_err) ? 32'h0 : ((word == CNT_WORD) ? m_cnt[b] : m_mem[b][word]);
        d_psel[b] = 1'b1; d_pen[b] = 1'b0; d_pwr[b] = wr; d_addr[b] = addr; d_wdata[b] = $urandom;
        @(negedge Hclk);
        d_pen[b] = 1'b1; d_addr[b] = $urandom; d_pwr[b] = 1'($urandom);
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (q_rdy[b]) begin
                chk("ready_cycle", 32'(k), 32'(ws_of[b]));
                chk("rdata", q_rdata[b], exp_rd);
                chk("slverr", 32'(q_err[b]), 32'(exp_err));
                d_wdata[b] = wdata;
                done = 1'b1;
                break;
            end
            chk("rdata_wait", q_rdata[b], exp_rd);
            chk("slverr_wait", 32'(q_err[b]), 32'h0);
            d_wdata[b] = $urandom;
            @(negedge Hclk);
        end
        if (!done) chk("ready_timeout", 32'h0, 32'h1);
        @(negedge Hclk);
        idle(b);
        chk("ready_after", 32'(q_rdy[b]), 32'h0);
        chk("rdata_after", q_rdata[b], 32'h0);
        m_cnt[b] = m_cnt[b] + 32'd1;
        if (wr && !exp_err) m_mem[b][word] = wdata;
    endtask

    initial begin
        int          b;
        logic        wr;
        logic [31:0] addr;
        Hreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(i); d_pwr[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
        end
        model_clear();
        @(negedge Hclk); @(negedge Hclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdata", q_rdata[i], 32'h0);
            chk("rst_ready", 32'(q_rdy[i]), 32'h0);
            chk("rst_slverr", 32'(q_err[i]), 32'h0);
        end
        Hreset = 1'b0;
        @(negedge Hclk);

        // basic write/read and counter readback
        xfer(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        xfer(0, 1'b0, 32'h10, 32'h0);
        xfer(0, 1'b0, 32'h3C, 32'h0);
        xfer(1, 1'b1, 32'h04, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h04, 32'h0);

        // error responses
        xfer(0, 1'b1, 32'h40, 32'h1111_1111);
        xfer(0, 1'b1, 32'h12, 32'h2222_2222);
        xfer(0, 1'b1, 32'h3C, 32'h3333_3333);
        xfer(0, 1'b0, 32'h10, 32'h0);
        xfer(0, 1'b0, 32'h3C, 32'h0);

        // back-to-back writes then readback
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'(4 * i), 32'h0);

        // abort during a wait state
        d_psel[1] = 1'b1; d_pen[1] = 1'b0; d_pwr[1] = 1'b1; d_addr[1] = 32'h08; d_wdata[1] = 32'hBAD0_BAD0;
        @(negedge Hclk); d_pen[1] = 1'b1;
        chk("abort_ready0", 32'(q_rdy[1]), 32'h0);
        @(negedge Hclk); idle(1);
        @(negedge Hclk);
        chk("abort_ready1", 32'(q_rdy[1]), 32'h0);
        xfer(1, 1'b0, 32'h08, 32'h0);
        xfer(1, 1'b0, 32'h3C, 32'h0);

        // Penable without a setup phase
        d_psel[0] = 1'b1; d_pen[0] = 1'b1; d_pwr[0] = 1'b1; d_addr[0] = 32'h08; d_wdata[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            chk("viol_ready", 32'(q_rdy[0]), 32'h0);
        end
        idle(0);
        @(negedge Hclk);
        xfer(0, 1'b0, 32'h08, 32'h0);
        xfer(0, 1'b0, 32'h3C, 32'h0);

        // reset during the access phase of a write
        d_psel[0] = 1'b1; d_pen[0] = 1'b0; d_pwr[0] = 1'b1; d_addr[0] = 32'h00; d_wdata[0] = 32'h1234;
        @(negedge Hclk); d_pen[0] = 1'b1; Hreset = 1'b1;
        @(negedge Hclk);
        chk("mid_rst_rdata", q_rdata[0], 32'h0);
        chk("mid_rst_ready", 32'(q_rdy[0]), 32'h0);
        Hreset = 1'b0; idle(0); model_clear();
        @(negedge Hclk);
        xfer(0, 1'b0, 32'h3C, 32'h0);
        for (int i = 0; i < CNT_WORD; i++) xfer(0, 1'b0, 32'(4 * i), 32'h0);

        // randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            b  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else begin
                addr = 32'($urandom_range(0, 32'h4F));
                if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            end
            xfer(b, wr, addr, $urandom);
            if ($urandom_range(0, 2) == 0) @(negedge Hclk);
        end

        // final sweep of every word on both instances
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < DEPTH; i++) xfer(j, 1'b0, 32'(4 * i), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
